// File: rtl/encoder83_serializer_pkg.sv
// Shared definitions for the 8-to-3 encoder serializer: widths, state encoding
// and small bit-counting helpers.
package encoder83_serializer_pkg;

    localparam int N      = 8;
    localparam int CODE_W = 3;
    localparam int CNT_W  = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ENCODE = 1'b1
    } state_e;

    // Number of set bits in a request word (0..8 fits in CNT_W bits).
    function automatic logic [CNT_W-1:0] popcount8(input logic [N-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    function automatic logic [N-1:0] onehot8(input logic [CODE_W-1:0] code);
        logic [N-1:0] mask;
        mask = '0;
        mask[code] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/encoder83_serializer_pri_enc83.sv
// Combinational 8-to-3 priority encoder: the lowest set bit wins.
// any_set is low (and code is 0) when the input word is all zeros.
module pri_enc83
    import encoder83_serializer_pkg::*;
(
    input  logic [N-1:0]      in_bits,
    output logic [CODE_W-1:0] code,
    output logic              any_set
);

    always_comb begin
        code    = '0;
        any_set = 1'b0;
        // Scan downward so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (in_bits[i]) begin
                code    = CODE_W'(i);
                any_set = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder83_serializer.sv
// Accepts a multi-hot 8-bit word and streams the index of each set bit,
// lowest first, one code per valid/ready beat.
module encoder83_serializer
    import encoder83_serializer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_bits,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_last,
    output logic [CODE_W-1:0] out_idx,
    output logic              busy,
    output logic              zero_err
);

    // Handshake rule for both ports: a transfer happens on a rising clk edge
    // where valid and ready are both high; the producer holds its payload
    // stable while valid is high and ready is low.

    state_e              state_q, state_d;
    logic [N-1:0]        pend_q, pend_d;
    logic [CODE_W-1:0]   idx_q, idx_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                zero_err_q, zero_err_d;

    logic [CODE_W-1:0]   enc_code;
    logic                enc_any;
    logic [N-1:0]        clear_mask;
    logic                single_bit;
    logic                encoding;
    logic                in_fire;
    logic                out_fire;

    pri_enc83 u_pri_enc83 (
        .in_bits (pend_q),
        .code    (enc_code),
        .any_set (enc_any)
    );

    assign encoding   = (state_q == ST_ENCODE);
    assign clear_mask = onehot8(enc_code);
    assign single_bit = enc_any && (popcount8(pend_q) == CNT_W'(1));

    // Ready is forced low during reset so nothing is accepted on that edge.
    assign in_ready  = !rst && !encoding;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign zero_err  = zero_err_q;
    assign out_code  = encoding ? enc_code : '0;
    assign out_last  = encoding && single_bit;
    assign out_idx   = encoding ? idx_q : '0;

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        zero_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_fire) begin
                    if (in_bits == '0) begin
                        zero_err_d = 1'b1;
                    end else begin
                        pend_d      = in_bits;
                        idx_d       = '0;
                        state_d     = ST_ENCODE;
                        out_valid_d = 1'b1;
                        busy_d      = 1'b1;
                    end
                end
            end
            ST_ENCODE: begin
                if (out_fire) begin
                    pend_d = pend_q & ~clear_mask;
                    if (single_bit) begin
                        // Final beat: counter returns to 0 so it reads 0 in IDLE.
                        idx_d       = '0;
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                    end else begin
                        idx_d = idx_q + CODE_W'(1);
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                pend_d      = '0;
                idx_d       = '0;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pend_q      <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            zero_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            zero_err_q  <= zero_err_d;
        end
    end

endmodule

// File: tb/tb_encoder83_serializer.sv
// Directed and randomized bench for encoder83_serializer with a queue-based
// reference of the expected code stream.
module tb_encoder83_serializer;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_bits;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_code;
    logic       out_last;
    logic [2:0] out_idx;
    logic       busy;
    logic       zero_err;

    int tests_run;
    int tests_failed;

    logic [2:0] exp_q[$];

    encoder83_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bits   (in_bits),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_last  (out_last),
        .out_idx   (out_idx),
        .busy      (busy),
        .zero_err  (zero_err)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: the code stream is simply the ascending list of set bit positions.
    task automatic build_expected(input logic [7:0] bits);
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            if (bits[i]) exp_q.push_back(3'(i));
        end
    endtask

    // Driver: offer one word, then consume its codes. The first 'stall' cycles
    // hold out_ready low, afterwards out_ready is high with ready_pct percent
    // probability. With 'hold' set, in_valid stays high with junk data throughout.
    task automatic run_word(input logic [7:0] bits, input int stall, input int ready_pct, input bit hold);
        int beat;
        int cyc;
        in_valid  = 1'b1;
        in_bits   = bits;
        out_ready = 1'b0;
        check("in_ready_idle", in_ready, 1);
        check("out_valid_idle", out_valid, 0);
        step();
        in_valid = hold;
        in_bits  = 8'($urandom);
        build_expected(bits);
        beat = 0;
        if (exp_q.size() == 0) begin
            check("zero_err_pulse", zero_err, 1);
            check("zero_out_valid", out_valid, 0);
            check("zero_in_ready", in_ready, 1);
            check("zero_busy", busy, 0);
            in_valid = 1'b0;
            step();
            check("zero_err_drop", zero_err, 0);
            check("zero_out_valid2", out_valid, 0);
            return;
        end
        check("zero_err_quiet", zero_err, 0);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            if (cyc < stall) out_ready = 1'b0;
            else             out_ready = ($urandom_range(0, 99) < ready_pct);
            if (hold) in_bits = 8'($urandom);
            check("out_valid", out_valid, 1);
            check("busy", busy, 1);
            check("in_ready_enc", in_ready, 0);
            check("out_code", out_code, exp_q[0]);
            check("out_idx", out_idx, beat);
            check("out_last", out_last, (exp_q.size() == 1));
            if (out_ready) begin
                void'(exp_q.pop_front());
                beat++;
            end
            step();
            cyc++;
        end
        check("drain_timeout", exp_q.size(), 0);
        check("post_out_valid", out_valid, 0);
        check("post_busy", busy, 0);
        check("post_in_ready", in_ready, 1);
        check("post_out_code", out_code, 0);
        check("post_out_idx", out_idx, 0);
        check("post_zero_err", zero_err, 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bits   = 8'h00;
        out_ready = 1'b0;
        step();
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_zero_err", zero_err, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("rst_release_in_ready", in_ready, 1);
        step();

        // Sparse word at full throughput
        run_word(8'hA4, 0, 100, 1'b0);
        // All-zero word
        run_word(8'h00, 0, 100, 1'b0);
        // Two-bit word with three stalled cycles first
        run_word(8'h81, 3, 100, 1'b0);
        // Full word: eight beats, out_idx 0..7
        run_word(8'hFF, 0, 100, 1'b0);
        // Input changes while encoding must be ignored
        run_word(8'h30, 0, 100, 1'b1);

        // Reset mid-word abandons the remaining codes
        in_valid = 1'b1;
        in_bits  = 8'h0F;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("mid_first_code", out_code, 0);
        check("mid_first_valid", out_valid, 1);
        step();
        check("mid_second_code", out_code, 1);
        rst = 1'b1;
        step();
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_idx", out_idx, 0);
        rst = 1'b0;
        #1;
        check("mid_release_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("mid_no_codes", out_valid, 0);
        end
        out_ready = 1'b0;

        // Randomized words with random backpressure and junk input traffic
        for (int n = 0; n < 40; n++) begin
            logic [7:0] w;
            w = 8'($urandom);
            if (n % 10 == 3) w = 8'h00;
            run_word(w, $urandom_range(0, 2), $urandom_range(30, 100), 1'($urandom_range(0, 1)));
            for (int g = 0; g < $urandom_range(0, 2); g++) begin
                step();
                check("gap_out_valid", out_valid, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
